// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for up to N_SRC device lines.
//
// Registers (word address on add_i):
//   0 MASK  r/w  1 enables the source
//   1 MODE  r/w  0 level, 1 edge
//   2 PEND  r/w1c (edge-mode bits only; level-mode bits follow irq_src_i)
//   3 VECT  ro   lowest enabled pending index, 0xFFFFFFFF when none
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   add_i      register word address
//   we_i       write enable
//   dat_i      write data
//   dat_o      registered read data (reflects this cycle's write)
//   irq_src_i  raw device irq lines, synchronous to clk_i
//   ack_i      exception-entry pulse, clears the current VECT source if edge mode
//   hwint_o    PEND & MASK
//   irq_o      OR of hwint_o
module irq_ctrl #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       add_i,
  input  logic             we_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic             ack_i,
  output logic [N_SRC-1:0] hwint_o,
  output logic             irq_o
);

  typedef enum logic [1:0] {
    AddrMask = 2'd0,
    AddrMode = 2'd1,
    AddrPend = 2'd2,
    AddrVect = 2'd3
  } addr_e;

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_q;
  logic [31:0]      dat_q, dat_d;

  logic [N_SRC-1:0] hwint;
  logic [N_SRC-1:0] lowest;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] rise;

  // Lowest set index, zero-extended; all ones when nothing is set.
  function automatic logic [31:0] vect_of(input logic [N_SRC-1:0] h);
    logic [31:0] v;
    v = '1;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (h[i]) v = 32'(i);
    end
    return v;
  endfunction

  always_comb begin
    hwint   = pend_q & mask_q;
    // Isolate the lowest set bit of hwint (two's-complement trick).
    lowest  = hwint & ((~hwint) + N_SRC'(1));
    // Ack only affects the selected source, and only if it is edge mode.
    ack_clr = ack_i ? (lowest & mode_q) : '0;
    w1c     = (we_i && (add_i == AddrPend)) ? dat_i[N_SRC-1:0] : '0;
    rise    = irq_src_i & ~src_q;

    // Level bits track the line; edge bits set on rise, with set beating clear.
    pend_d = (~mode_q & irq_src_i) | (mode_q & (rise | (pend_q & ~(w1c | ack_clr))));
    mask_d = (we_i && (add_i == AddrMask)) ? dat_i[N_SRC-1:0] : mask_q;
    mode_d = (we_i && (add_i == AddrMode)) ? dat_i[N_SRC-1:0] : mode_q;

    // Read data reflects register contents after this cycle's update.
    dat_d = '0;
    unique case (add_i)
      AddrMask: dat_d = 32'(mask_d);
      AddrMode: dat_d = 32'(mode_d);
      AddrPend: dat_d = 32'(pend_d);
      AddrVect: dat_d = vect_of(pend_d & mask_d);
      default:  dat_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      src_q  <= '0;
      dat_q  <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      src_q  <= irq_src_i;
      dat_q  <= dat_d;
    end
  end

  assign dat_o   = dat_q;
  assign hwint_o = hwint;
  assign irq_o   = |hwint;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed, table-driven bench for irq_ctrl with N_SRC = 6.
module tb_irq_ctrl;

  localparam int unsigned NSrc = 6;

  logic            clk_i;
  logic            rst_i;
  logic [1:0]      add_i;
  logic            we_i;
  logic [31:0]     dat_i;
  logic [31:0]     dat_o;
  logic [NSrc-1:0] irq_src_i;
  logic            ack_i;
  logic [NSrc-1:0] hwint_o;
  logic            irq_o;

  irq_ctrl #(.N_SRC(NSrc)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .add_i     (add_i),
    .we_i      (we_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .irq_src_i (irq_src_i),
    .ack_i     (ack_i),
    .hwint_o   (hwint_o),
    .irq_o     (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]      add;
    logic            we;
    logic [31:0]     dat;
    logic [NSrc-1:0] src;
    logic            ack;
    logic [31:0]     exp_dat;
    logic [NSrc-1:0] exp_hw;
  } vec_t;

  localparam int NVec = 24;
  vec_t vecs [NVec];

  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, then compare away from the edge.
  task automatic step(input string name, input logic [1:0] a, input logic w,
                      input logic [31:0] d, input logic [NSrc-1:0] s, input logic k,
                      input logic [31:0] exp_dat, input logic [NSrc-1:0] exp_hw);
    add_i     = a;
    we_i      = w;
    dat_i     = d;
    irq_src_i = s;
    ack_i     = k;
    @(posedge clk_i);
    #1;
    chk({name, ".dat_o"}, dat_o, exp_dat);
    chk({name, ".hwint_o"}, 32'(hwint_o), 32'(exp_hw));
    chk({name, ".irq_o"}, 32'(irq_o), 32'(|exp_hw));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //               add   we    dat            src    ack   exp_dat        exp_hw
    vecs[0]  = '{2'd0, 1'b0, 32'h0,         6'h00, 1'b0, 32'h0,         6'h00};
    vecs[1]  = '{2'd0, 1'b1, 32'hFFFF_FFFF, 6'h00, 1'b0, 32'h3F,        6'h00};
    vecs[2]  = '{2'd0, 1'b1, 32'h01,        6'h01, 1'b0, 32'h01,        6'h01};
    vecs[3]  = '{2'd2, 1'b1, 32'h01,        6'h01, 1'b0, 32'h01,        6'h01};
    vecs[4]  = '{2'd0, 1'b0, 32'h0,         6'h00, 1'b0, 32'h01,        6'h00};
    vecs[5]  = '{2'd3, 1'b1, 32'h05,        6'h00, 1'b0, 32'hFFFF_FFFF, 6'h00};
    vecs[6]  = '{2'd1, 1'b1, 32'h02,        6'h00, 1'b0, 32'h02,        6'h00};
    vecs[7]  = '{2'd0, 1'b1, 32'h02,        6'h02, 1'b0, 32'h02,        6'h02};
    vecs[8]  = '{2'd2, 1'b0, 32'h0,         6'h00, 1'b0, 32'h02,        6'h02};
    vecs[9]  = '{2'd3, 1'b0, 32'h0,         6'h00, 1'b0, 32'h01,        6'h02};
    vecs[10] = '{2'd3, 1'b0, 32'h0,         6'h00, 1'b1, 32'hFFFF_FFFF, 6'h00};
    vecs[11] = '{2'd2, 1'b0, 32'h0,         6'h00, 1'b1, 32'h0,         6'h00};
    vecs[12] = '{2'd1, 1'b1, 32'h3F,        6'h00, 1'b0, 32'h3F,        6'h00};
    vecs[13] = '{2'd0, 1'b1, 32'h3F,        6'h09, 1'b0, 32'h3F,        6'h09};
    vecs[14] = '{2'd3, 1'b0, 32'h0,         6'h09, 1'b0, 32'h0,         6'h09};
    vecs[15] = '{2'd3, 1'b0, 32'h0,         6'h09, 1'b1, 32'h03,        6'h08};
    vecs[16] = '{2'd3, 1'b0, 32'h0,         6'h00, 1'b1, 32'hFFFF_FFFF, 6'h00};
    vecs[17] = '{2'd2, 1'b1, 32'h04,        6'h04, 1'b0, 32'h04,        6'h04};
    vecs[18] = '{2'd2, 1'b1, 32'h04,        6'h04, 1'b0, 32'h0,         6'h00};
    vecs[19] = '{2'd0, 1'b1, 32'h0,         6'h01, 1'b0, 32'h0,         6'h00};
    vecs[20] = '{2'd3, 1'b0, 32'h0,         6'h01, 1'b0, 32'hFFFF_FFFF, 6'h00};
    vecs[21] = '{2'd0, 1'b1, 32'h01,        6'h01, 1'b0, 32'h01,        6'h01};
    vecs[22] = '{2'd1, 1'b1, 32'h3E,        6'h00, 1'b0, 32'h3E,        6'h01};
    vecs[23] = '{2'd2, 1'b0, 32'h0,         6'h00, 1'b0, 32'h0,         6'h00};

    rst_i     = 1'b0;
    add_i     = 2'd0;
    we_i      = 1'b0;
    dat_i     = 32'h0;
    irq_src_i = '0;
    ack_i     = 1'b0;

    // Reset state, with a source active to show reset dominates.
    #12;
    irq_src_i = 6'h3F;
    @(posedge clk_i);
    #1;
    chk("reset.dat_o", dat_o, 32'h0);
    chk("reset.hwint_o", 32'(hwint_o), 32'h0);
    chk("reset.irq_o", 32'(irq_o), 32'h0);
    irq_src_i = '0;
    #3 rst_i = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      step($sformatf("vec%0d", i), vecs[i].add, vecs[i].we, vecs[i].dat, vecs[i].src,
           vecs[i].ack, vecs[i].exp_dat, vecs[i].exp_hw);
    end

    // Edge source 0 pending, then asynchronous reset between clocks.
    step("arm_edge", 2'd1, 1'b1, 32'h01, 6'h01, 1'b0, 32'h01, 6'h01);
    step("edge_held", 2'd2, 1'b0, 32'h0, 6'h01, 1'b0, 32'h01, 6'h01);
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst.hwint_o", 32'(hwint_o), 32'h0);
    chk("async_rst.irq_o", 32'(irq_o), 32'h0);
    chk("async_rst.dat_o", dat_o, 32'h0);
    @(posedge clk_i);
    #3 rst_i = 1'b1;

    // Source held high across reset: after clearing, edge mode must not re-fire
    // until the line goes low and high again.
    step("post_mode", 2'd1, 1'b1, 32'h01, 6'h01, 1'b0, 32'h01, 6'h00);
    step("post_mask", 2'd0, 1'b1, 32'h01, 6'h01, 1'b0, 32'h01, 6'h01);
    step("post_w1c", 2'd2, 1'b1, 32'h01, 6'h01, 1'b0, 32'h0, 6'h00);
    step("post_hold1", 2'd2, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0, 6'h00);
    step("post_hold2", 2'd2, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0, 6'h00);
    step("post_low", 2'd2, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0, 6'h00);
    step("post_rise", 2'd2, 1'b0, 32'h0, 6'h01, 1'b0, 32'h01, 6'h01);
    step("post_vect", 2'd3, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0, 6'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
